adder_error_monitor: RTL and testbench
======================================

# adder_error_monitor

Sequential error-statistics collector placed directly downstream of the approximate adders, including the hybrid approximate/ripple-carry adder. Each beat takes the adder's approximate result `{cout, sum}` together with a golden exact result. Over a fixed window of 2^NS_LOG2 beats it accumulates:
- error count
- maximum error distance (ED)
- total ED

The window ends with a one-cycle `done` pulse. It is used in the evaluation harness to characterise adder accuracy in hardware or simulation.

## Interface
Parameters:
- `W`, 32, operand width of the adder under test; results are W+1 bits wide (carry-out included).
- `NS_LOG2`, 10, log2 of samples per window (default 1024).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle pulse that opens a window; honoured only in IDLE.
- `s_valid`  in  1  sample beat valid.
- `s_ready`  out  1  monitor accepts a beat; a beat transfers when `s_valid & s_ready`.
- `approx`  in  W+1  approximate result `{cout, sum}`.
- `exact`  in  W+1  exact result `{cout, sum}`.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse when results are final.
- `err_cnt`  out  NS_LOG2+1  number of beats with approx ≠ exact.
- `max_ed`  out  W+1  largest |approx − exact| in the window.
- `sum_ed`  out  W+1+NS_LOG2  sum of |approx − exact|; sized so it never overflows.
- `bias`  out  W+2+NS_LOG2  signed sum of (approx − exact); present only with `ERR_BIAS_EN`.

## Operation
States: IDLE, RUN, DRAIN, DONE.

IDLE:
- `s_ready` = 0 and `busy` = 0.
- Result outputs hold the previous window's values.
- `start` → clear the beat counter, `err_cnt`, `max_ed`, `sum_ed` and `bias`, then go to RUN.

RUN:
- `s_ready` = 1 and `busy` = 1.
- Each transfer increments the beat counter (NS_LOG2+1 bits).
- Stage 1 registers the following for each transfer:
  - d = approx − exact, zero-extended to W+2 bits, as a two's-complement difference;
  - ed = |d|, W+1 bits;
  - nz = (d ≠ 0);
  - a stage-1 valid flag.
- Stage 2 updates on a valid stage-1 entry:
  - `err_cnt` += nz;
  - `max_ed` = max(`max_ed`, ed);
  - `sum_ed` += ed;
  - `bias` += sign-extended d.
- On the transfer that makes the counter equal 2^NS_LOG2, go to DRAIN.

DRAIN:
- `s_ready` = 0 and `busy` = 1.
- Stays one cycle to retire the last stage-1 entry, then goes to DONE.

DONE:
- `done` = 1 and `busy` = 0 for one cycle.
- Returns to IDLE.

Rules and boundary conditions:
- `start` in RUN, DRAIN or DONE is ignored.
- Result outputs update only in stage 2. Mid-window values are visible but not guaranteed consistent until `done`.
- While `s_ready` = 0, `s_valid` is ignored. Data on an unaccepted beat has no effect.
- ED arithmetic is exact; there is no saturation. The worst case is approx = 0 and exact = 2^(W+1) − 1.
- Reset in any state:
  - next state IDLE;
  - beat counter, all result outputs, `done`, `busy` and `s_ready` = 0;
  - stage-1 valid cleared, so an in-flight window is discarded.

## Timing
- Reset values: every output is 0.
- `start` sampled at cycle t → RUN from t+1; `s_ready` = 1 in t+1.
- Beat accepted in cycle k → stage 1 registered at end of k → accumulators updated at end of k+1.
- Last beat accepted in cycle L:
  - `s_ready` = 0 from L+1 (DRAIN);
  - `done` = 1 in L+2;
  - IDLE from L+3.
- Results are final and stable from L+2 until the next `start` or reset.
- Throughput: one beat per cycle; minimum window time is 2^NS_LOG2 + 3 cycles from `start`.
- `start` may be asserted in the same cycle as `done` is high (state DONE). It is ignored because `start` is honoured only in IDLE.

## Configuration
- Macro `ERR_BIAS_EN`.
- Defined:
  - stage 1 keeps signed d;
  - the `bias` port and its W+2+NS_LOG2-bit accumulator exist;
  - `bias` clears on `start` and on reset.
- Undefined:
  - the `bias` port and its logic are absent;
  - all other behaviour is identical.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with random inputs → all outputs 0, state IDLE, `s_ready` = 0.
- Zero error (W = 32, NS_LOG2 = 10): `start`, then 1024 back-to-back beats with approx = exact random → `err_cnt` = 0, `max_ed` = 0, `sum_ed` = 0; `done` exactly 2 cycles after the last accept.
- Sparse error: every 4th beat has approx = exact − 1, all others equal → `err_cnt` = 256, `max_ed` = 1, `sum_ed` = 256; `bias` = −256 with `ERR_BIAS_EN`.
- Extreme ED: one beat with approx = 0 and exact = 0x1_FFFF_FFFF, all others equal → `err_cnt` = 1, `max_ed` = `sum_ed` = 0x1_FFFF_FFFF; `bias` = −0x1_FFFF_FFFF.
- Handshake: random `s_valid` gaps plus a `start` pulse mid-RUN → exactly 1024 transfers counted, the extra `start` has no effect, and `s_valid` asserted in DRAIN, DONE or IDLE is not accepted.
- Reset mid-window: assert `rst_n` = 0 after 100 beats with errors → outputs 0 and IDLE next cycle; a new `start` then 1024 equal beats → all results 0.

Source files
------------

// File: rtl/adder_error_monitor.sv
// rtl/adder_error_monitor.sv - windowed error statistics for approximate adders; optional signed bias via ERR_BIAS_EN
module adder_error_monitor #(
  parameter int W       = 32,
  parameter int NS_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [W:0]              approx,
  input  logic [W:0]              exact,
  output logic                    busy,
  output logic                    done,
  output logic [NS_LOG2:0]        err_cnt,
  output logic [W:0]              max_ed,
  output logic [W+NS_LOG2:0]      sum_ed
`ifdef ERR_BIAS_EN
  ,
  output logic signed [W+1+NS_LOG2:0] bias
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // counter value just before the transfer that completes the window
  localparam logic [NS_LOG2:0] LP_LAST = {1'b0, {NS_LOG2{1'b1}}};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_xfer;
  logic                   w_clear;
  logic [NS_LOG2:0]       r_cnt;

  logic [W+1:0]           w_diff;
  logic [W:0]             w_ed;

  logic                   r_s1_vld;
  logic                   r_s1_nz;
  logic [W:0]             r_s1_ed;

  logic [NS_LOG2:0]       r_err_cnt;
  logic [W:0]             r_max_ed;
  logic [W+NS_LOG2:0]     r_sum_ed;

  assign w_xfer  = s_valid & s_ready;
  assign w_clear = (r_state == S_IDLE) & start;

  // difference is taken one bit wider so the sign of approx-exact survives
  assign w_diff = {1'b0, approx} - {1'b0, exact};
  assign w_ed   = w_diff[W+1] ? (~w_diff[W:0] + {{W{1'b0}}, 1'b1}) : w_diff[W:0];

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state and handshake/status outputs
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid && (r_cnt == LP_LAST)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // beat counter, cleared when a window opens
  always_ff @(posedge clk) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_clear) r_cnt <= '0;
    else if (w_xfer)  r_cnt <= r_cnt + {{NS_LOG2{1'b0}}, 1'b1};
  end

  // stage 1: capture error magnitude and nonzero flag of each accepted beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_nz  <= 1'b0;
      r_s1_ed  <= '0;
    end else begin
      r_s1_vld <= w_xfer;
      if (w_xfer) begin
        r_s1_nz <= (w_diff != '0);
        r_s1_ed <= w_ed;
      end
    end
  end

  // stage 2: fold the stage-1 entry into the window statistics
  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_err_cnt <= '0;
      r_max_ed  <= '0;
      r_sum_ed  <= '0;
    end else if (r_s1_vld) begin
      r_err_cnt <= r_err_cnt + {{NS_LOG2{1'b0}}, r_s1_nz};
      if (r_s1_ed > r_max_ed) r_max_ed <= r_s1_ed;
      r_sum_ed  <= r_sum_ed + {{NS_LOG2{1'b0}}, r_s1_ed};
    end
  end

  assign err_cnt = r_err_cnt;
  assign max_ed  = r_max_ed;
  assign sum_ed  = r_sum_ed;

`ifdef ERR_BIAS_EN
  logic [W+1:0]               r_s1_d;
  logic [W+1+NS_LOG2:0]       r_bias;

  // stage 1: keep the signed difference for the bias accumulator
  always_ff @(posedge clk) begin
    if (!rst_n)      r_s1_d <= '0;
    else if (w_xfer) r_s1_d <= w_diff;
  end

  // stage 2: signed running sum of approx-exact
  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) r_bias <= '0;
    else if (r_s1_vld)     r_bias <= r_bias + {{NS_LOG2{r_s1_d[W+1]}}, r_s1_d};
  end

  assign bias = r_bias;
`endif

endmodule

// File: tb/tb_adder_error_monitor.sv
// tb/tb_adder_error_monitor.sv - directed self-checking bench for adder_error_monitor
module tb_adder_error_monitor;
  localparam int W  = 32;
  localparam int NS = 10;
  localparam int NBEATS = 1 << NS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              s_valid;
  logic              s_ready;
  logic [W:0]        approx;
  logic [W:0]        exact;
  logic              busy;
  logic              done;
  logic [NS:0]       err_cnt;
  logic [W:0]        max_ed;
  logic [W+NS:0]     sum_ed;
`ifdef ERR_BIAS_EN
  logic signed [W+1+NS:0] bias;
`endif

  int total = 0;
  int bad   = 0;

  adder_error_monitor #(.W(W), .NS_LOG2(NS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .approx  (approx),
    .exact   (exact),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .max_ed  (max_ed),
    .sum_ed  (sum_ed)
`ifdef ERR_BIAS_EN
    ,
    .bias    (bias)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rnd33(output logic [W:0] v);
    v[31:0] = $urandom();
    v[32]   = (($urandom() & 1) != 0);
  endtask

  task automatic set_beat(input int mode, input int b);
    logic [W:0] e;
    rnd33(e);
    if (e == '0) e = 33'd1;
    exact  = e;
    approx = e;
    case (mode)
      1: if ((b % 4) == 3) approx = e - 33'd1;
      2: if (b == 517) begin approx = '0; exact = 33'h1_FFFF_FFFF; end
      3: approx = e ^ 33'h4;
      default: ;
    endcase
  endtask

  task automatic check_results(input string pfx, input logic [63:0] e_cnt,
                               input logic [63:0] e_max, input logic [63:0] e_sum,
                               input logic [63:0] e_bias);
    chk({pfx, "_err_cnt"}, 64'(err_cnt), e_cnt);
    chk({pfx, "_max_ed"},  64'(max_ed),  e_max);
    chk({pfx, "_sum_ed"},  64'(sum_ed),  e_sum);
`ifdef ERR_BIAS_EN
    chk({pfx, "_bias"},    64'(bias),    e_bias);
`else
    if (e_bias != 64'hDEAD) ;
`endif
  endtask

  task automatic run_window(input int mode, input bit gaps, input bit mid_start,
                            input logic [63:0] e_cnt, input logic [63:0] e_max,
                            input logic [63:0] e_sum, input logic [63:0] e_bias);
    int beats;
    int cyc;
    int drops;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_ready", 64'(s_ready), 64'd1);
    chk("run_busy",  64'(busy),    64'd1);
    beats = 0;
    cyc   = 0;
    drops = 0;
    while (beats < NBEATS && cyc < 6000) begin
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (s_valid) set_beat(mode, beats);
      else begin approx = '0; exact = '1; end
      start = mid_start && (cyc == 600);
      if (!s_ready) drops++;
      if (s_valid && s_ready) beats++;
      cyc++;
      tick();
    end
    start = 1'b0;
    chk("beats_accepted", 64'(beats), 64'(NBEATS));
    chk("ready_drops",    64'(drops), 64'd0);
    // L+1: drain, an offered beat with large error must be ignored
    s_valid = 1'b1;
    approx  = '0;
    exact   = '1;
    chk("drain_ready", 64'(s_ready), 64'd0);
    chk("drain_busy",  64'(busy),    64'd1);
    chk("drain_done",  64'(done),    64'd0);
    tick();
    // L+2: done pulse, results final; a start here is ignored
    chk("done_pulse", 64'(done),    64'd1);
    chk("done_busy",  64'(busy),    64'd0);
    chk("done_ready", 64'(s_ready), 64'd0);
    check_results("final", e_cnt, e_max, e_sum, e_bias);
    start = 1'b1;
    tick();
    // L+3: idle, results held
    start = 1'b0;
    chk("idle_done",  64'(done),    64'd0);
    chk("idle_busy",  64'(busy),    64'd0);
    chk("idle_ready", 64'(s_ready), 64'd0);
    tick();
    check_results("hold", e_cnt, e_max, e_sum, e_bias);
    s_valid = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    start   = 1'b1;
    s_valid = 1'b1;
    rnd33(approx);
    rnd33(exact);
    tick();
    rnd33(approx);
    start = 1'b0;
    tick();
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_busy",  64'(busy),    64'd0);
    chk("rst_done",  64'(done),    64'd0);
    check_results("rst", 64'd0, 64'd0, 64'd0, 64'd0);
    rst_n   = 1'b1;
    s_valid = 1'b0;
    tick();
    chk("idle_after_rst_ready", 64'(s_ready), 64'd0);

    // zero error
    run_window(0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    // sparse error: every 4th beat approx = exact - 1
    run_window(1, 1'b0, 1'b0, 64'd256, 64'd1, 64'd256, 64'hFFFF_FFFF_FFFF_FF00);
    // extreme error distance on a single beat
    run_window(2, 1'b0, 1'b0, 64'd1, 64'h1_FFFF_FFFF, 64'h1_FFFF_FFFF,
               64'hFFFF_FFFE_0000_0001);
    // handshake gaps plus a stray start mid-run
    run_window(1, 1'b1, 1'b1, 64'd256, 64'd1, 64'd256, 64'hFFFF_FFFF_FFFF_FF00);

    // reset mid-window after 100 erroneous beats
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (n < 100) begin
      s_valid = 1'b1;
      set_beat(3, n);
      n++;
      tick();
    end
    chk("mid_err_cnt", 64'(err_cnt), 64'd99);
    chk("mid_sum_ed",  64'(sum_ed),  64'd396);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_ready", 64'(s_ready), 64'd0);
    chk("mrst_busy",  64'(busy),    64'd0);
    chk("mrst_done",  64'(done),    64'd0);
    check_results("mrst", 64'd0, 64'd0, 64'd0, 64'd0);
    s_valid = 1'b0;
    tick();
    chk("mrst_idle_ready", 64'(s_ready), 64'd0);
    run_window(0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
